// File: rtl/i2s_pkg.sv
// Shared constants and width helpers for the I2S/TDM transmitter and receiver.
package i2s_pkg;

  // ws level that marks the first half of the frame (slot 0 side).
  localparam logic I2S_WS_LEFT = 1'b0;

  // FIFO pointer width: one extra wrap bit so full and empty can be told apart.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Width of the per-slot bit counter.
  function automatic int bit_cnt_w(input int slot_width);
    return (slot_width > 1) ? $clog2(slot_width) : 1;
  endfunction

  // Width of the slot counter; it must also hold the "past last slot" value.
  function automatic int slot_cnt_w(input int num_ch);
    return $clog2(num_ch + 1);
  endfunction

  // Width of one whole frame vector (channel 0 in the low bits).
  function automatic int frame_w(input int num_ch, input int data_w);
    return num_ch * data_w;
  endfunction

endpackage

// File: rtl/i2s_frame_fifo.sv
// Single-clock frame FIFO with wrap-bit pointers. Push when full and pop when
// empty are ignored; push and pop in the same cycle are both honoured.
module i2s_frame_fifo
  import i2s_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_push,
  input  logic [WIDTH-1:0]          i_data,
  input  logic                      i_pop,
  output logic [WIDTH-1:0]          o_data,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [ptr_w(DEPTH)-1:0]   o_count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Pointer update; pointers wrap naturally through the extra bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/i2s_tdm_transmit.sv
// I2S / TDM transmitter, slave to external sck/ws, fed by AXI-Stream.
// Whole frames are buffered in i2s_frame_fifo and serialised MSB first.
// Optional macro I2S_TX_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module i2s_tdm_transmit
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int SLOT_WIDTH   = 32,
  parameter int NUM_CHANNELS = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  S_AXIS_ACLK,
  input  logic                  S_AXIS_ARESET,
  input  logic                  S_AXIS_TVALID,
  input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                  S_AXIS_TLAST,
  output logic                  S_AXIS_TREADY,
  input  logic                  sck,
  input  logic                  ws,
  output logic                  sd,
  output logic                  underrun,
  output logic                  frame_err,
`ifdef I2S_TX_UNDERRUN_CNT_EN
  output logic [15:0]           underrun_cnt,
`endif
  input  logic                  clr_status
);

  localparam int FW = frame_w(NUM_CHANNELS, DATA_WIDTH);
  localparam int RW = FW - DATA_WIDTH;  // channels 1..N-1 only
  localparam int PW = ptr_w(FIFO_DEPTH);
  localparam int BW = bit_cnt_w(SLOT_WIDTH);
  localparam int CW = slot_cnt_w(NUM_CHANNELS);

  // Left-align a sample in its slot; trailing bits are zero padding.
  function automatic logic [SLOT_WIDTH-1:0] align(input logic [DATA_WIDTH-1:0] s);
    return SLOT_WIDTH'(s) << (SLOT_WIDTH - DATA_WIDTH);
  endfunction

  logic [1:0]            r_sck_sync, r_ws_sync;
  logic                  r_sck_prev, r_ws_smp;
  logic                  w_sck_rise, w_sck_fall, w_frame_start;
  logic                  r_tready;
  logic [CW-1:0]         r_ch_in;
  logic [RW-1:0]         r_asm;
  logic                  w_accept, w_last_ch, w_push, w_pop, w_tlast_err;
  logic [FW-1:0]         w_push_data, w_fifo_data;
  logic                  w_fifo_full, w_fifo_empty;
  logic [PW-1:0]         w_fifo_count, w_cnt_next;
  logic [RW-1:0]         r_frame;
  logic [SLOT_WIDTH-1:0] r_shift;
  logic [BW-1:0]         r_bit_cnt;
  logic [CW-1:0]         r_slot_cnt, w_next_slot;
  logic [DATA_WIDTH-1:0] w_next_sample;
  logic                  r_sd, r_underrun, r_frame_err;

  assign w_sck_rise    = r_sck_sync[1] && !r_sck_prev;
  assign w_sck_fall    = !r_sck_sync[1] && r_sck_prev;
  assign w_frame_start = w_sck_rise && (r_ws_smp == ~I2S_WS_LEFT) && (r_ws_sync[1] == I2S_WS_LEFT);

  // Two-flop synchronisers, sck edge history and ws sampled on sck rise.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      r_sck_sync <= '0;
      r_ws_sync  <= '0;
      r_sck_prev <= 1'b0;
      r_ws_smp   <= 1'b0;
    end else begin
      r_sck_sync <= {r_sck_sync[0], sck};
      r_ws_sync  <= {r_ws_sync[0], ws};
      r_sck_prev <= r_sck_sync[1];
      if (w_sck_rise) r_ws_smp <= r_ws_sync[1];
    end
  end

  // Handshake: a beat transfers on a clock edge where S_AXIS_TVALID and
  // S_AXIS_TREADY are both high; TREADY is registered from the FIFO occupancy
  // expected after this cycle, so an accepted last beat always finds space.
  assign w_accept    = S_AXIS_TVALID && r_tready;
  assign w_last_ch   = (r_ch_in == CW'(NUM_CHANNELS - 1));
  assign w_push      = w_accept && w_last_ch;
  assign w_push_data = {S_AXIS_TDATA, r_asm};
  assign w_tlast_err = w_accept && (S_AXIS_TLAST != w_last_ch);
  assign w_pop       = w_frame_start && !w_fifo_empty;

  // Occupancy after this cycle's push/pop, used for the registered TREADY.
  always_comb begin
    w_cnt_next = w_fifo_count;
    if (w_push && !w_fifo_full) w_cnt_next = w_cnt_next + PW'(1);
    if (w_pop)                  w_cnt_next = w_cnt_next - PW'(1);
  end

  // Frame assembly: early TLAST drops the partial frame; a missing TLAST
  // on the last channel still pushes the frame.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      r_tready <= 1'b0;
      r_ch_in  <= '0;
      r_asm    <= '0;
    end else begin
      r_tready <= (w_cnt_next != PW'(FIFO_DEPTH));
      if (w_accept) begin
        if (w_last_ch || S_AXIS_TLAST) begin
          r_ch_in <= '0;
        end else begin
          r_asm[r_ch_in*DATA_WIDTH +: DATA_WIDTH] <= S_AXIS_TDATA;
          r_ch_in <= r_ch_in + CW'(1);
        end
      end
    end
  end

  i2s_frame_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (S_AXIS_ACLK),
    .i_rst   (S_AXIS_ARESET),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // Sample for the following slot; zeros once the last channel has gone out.
  assign w_next_slot = r_slot_cnt + CW'(1);
  always_comb begin
    w_next_sample = '0;
    for (int k = 1; k < NUM_CHANNELS; k++) begin
      if (w_next_slot == CW'(k)) w_next_sample = r_frame[(k-1)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Serialiser: load on frame_start, shift on sck rise, drive sd on sck fall.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      r_frame    <= '0;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_slot_cnt <= '0;
      r_sd       <= 1'b0;
    end else begin
      if (w_frame_start) begin
        r_bit_cnt  <= '0;
        r_slot_cnt <= '0;
        if (!w_fifo_empty) begin
          r_frame <= w_fifo_data[FW-1:DATA_WIDTH];
          r_shift <= align(w_fifo_data[DATA_WIDTH-1:0]);
        end else begin
          r_frame <= '0;
          r_shift <= '0;
        end
      end else if (w_sck_rise) begin
        if (r_bit_cnt == BW'(SLOT_WIDTH - 1)) begin
          r_bit_cnt <= '0;
          if (r_slot_cnt != CW'(NUM_CHANNELS)) r_slot_cnt <= w_next_slot;
          r_shift <= align(w_next_sample);
        end else begin
          r_bit_cnt <= r_bit_cnt + BW'(1);
          r_shift   <= r_shift << 1;
        end
      end
      if (w_sck_fall) r_sd <= r_shift[SLOT_WIDTH-1];
    end
  end

  // Sticky status flags; a new error in the same cycle as clr_status wins.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      r_underrun  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_frame_start && w_fifo_empty) r_underrun <= 1'b1;
      else if (clr_status)               r_underrun <= 1'b0;
      if (w_tlast_err)                   r_frame_err <= 1'b1;
      else if (clr_status)               r_frame_err <= 1'b0;
    end
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] r_underrun_cnt;

  // Saturating count of underrun frames.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      r_underrun_cnt <= '0;
    end else if (w_frame_start && w_fifo_empty) begin
      if (clr_status)                    r_underrun_cnt <= 16'd1;
      else if (r_underrun_cnt != 16'hFFFF) r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end else if (clr_status) begin
      r_underrun_cnt <= '0;
    end
  end

  assign underrun_cnt = r_underrun_cnt;
`endif

  assign S_AXIS_TREADY = r_tready;
  assign sd            = r_sd;
  assign underrun      = r_underrun;
  assign frame_err     = r_frame_err;

endmodule
